pipe_ctrl_unit: RTL and testbench
=================================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 The block SHALL have parameter CP2_TIMEOUT, default 16: the maximum number of CP2_WAIT cycles before abort, legal range 2..255.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 Port id_en SHALL be an input, 1 bit: the ID/EX register holds a valid instruction.
REQ-005 Port id_mem_op SHALL be an input, `MEMOPBUS: the memory op of the instruction in ID/EX.
REQ-006 Port id_dst_addr SHALL be an input, `REGADDRBUS: the destination register of that instruction.
REQ-007 Port id_gpr_we_ SHALL be an input, 1 bit: active-low GPR write enable of that instruction.
REQ-008 Ports ra_addr and rb_addr SHALL be inputs, `REGADDRBUS: source registers of the instruction currently being decoded.
REQ-009 Ports ra_used and rb_used SHALL be inputs, 1 bit: the matching source register is actually read.
REQ-010 Port br_taken SHALL be an input, 1 bit: the decoder resolved a taken branch.
REQ-011 Port exp_valid SHALL be an input, 1 bit: an exception was raised in a later stage.
REQ-012 Port cp2_req SHALL be an input, 1 bit: the decoded instruction is a CP2 instruction.
REQ-013 Port cp2_ack SHALL be an input, 1 bit: the coprocessor has consumed the instruction.
REQ-014 Ports if_stall, id_stall, if_flush and id_flush SHALL be outputs, 1 bit each: pipeline register controls.
REQ-015 Port cp2_irenable_s SHALL be an output, 1 bit: the issue strobe to the ID register's CP2 path.
REQ-016 Port cp2_err SHALL be an output, 1 bit: a one-cycle pulse on CP2 timeout.

Function
REQ-017 The FSM states SHALL be IDLE, CP2_ISSUE, CP2_WAIT and EXC_FLUSH.
REQ-018 All stall, flush and strobe outputs SHALL be combinational from the current state and inputs, so their latency is 0 cycles.
REQ-019 Priority SHALL be: exception > CP2 sequencing > load-use hazard > branch.
REQ-020 A load-use hazard SHALL exist when all of the following hold: id_en=1, id_mem_op=`MEMOPLDW, id_gpr_we_=0, id_dst_addr!=0, and (ra_used and ra_addr==id_dst_addr) or (rb_used and rb_addr==id_dst_addr).
REQ-021 In IDLE, a hazard SHALL produce if_stall=1 and id_flush=1 (a bubble) for exactly the cycles the condition holds, with id_stall=0.
REQ-022 In IDLE with no hazard, br_taken=1 SHALL produce if_flush=1 for one cycle.
REQ-023 In IDLE with no hazard, cp2_req=1 SHALL transition to CP2_ISSUE; a hazard defers the CP2 issue.
REQ-024 In CP2_ISSUE, the outputs SHALL be cp2_irenable_s=1, if_stall=1 and id_stall=1 for one cycle, followed by CP2_WAIT with the timeout counter cleared.
REQ-025 In CP2_WAIT, the outputs SHALL be if_stall=1 and id_stall=1.
REQ-026 In CP2_WAIT, cp2_ack=1 SHALL return the FSM to IDLE, with stalls released in that same cycle.
REQ-027 In CP2_WAIT, when the counter equals CP2_TIMEOUT-1 without an ack, the block SHALL pulse cp2_err=1, return to IDLE and assert id_flush=1 that cycle.
REQ-028 If cp2_ack arrives in the same cycle as the timeout terminal count, the ack SHALL win and no cp2_err SHALL be raised.
REQ-029 The timeout counter SHALL be 8 bits wide and SHALL NOT wrap; it is held at the terminal value.
REQ-030 exp_valid=1 in any state SHALL assert if_flush=1 and id_flush=1 that cycle, abort any CP2 transfer (cp2_irenable_s=0) and enter EXC_FLUSH.
REQ-031 EXC_FLUSH SHALL hold if_flush=1 and id_flush=1 for one more cycle, then return to IDLE.
REQ-032 A stall and a flush on the same stage SHALL never be asserted together; flush takes precedence.

Reset
REQ-033 While reset=1 at a clock edge, the state SHALL become IDLE, the counter SHALL be cleared and all outputs SHALL be 0.
REQ-034 A reset during CP2_WAIT SHALL drop the stalls on the next cycle and SHALL NOT emit cp2_err.

Configuration
REQ-035 With PIPE_CTRL_PERF_EN defined, the block SHALL add outputs stall_cnt [15:0] and flush_cnt [15:0].
REQ-036 stall_cnt and flush_cnt SHALL be saturating counters of cycles with if_stall=1 and if_flush=1 respectively, cleared by reset.
REQ-037 Without PIPE_CTRL_PERF_EN, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-038 The FSM state encoding and the PIPE_CTRL_ST_* constants SHALL live in the shared header alongside bus.vh and signal.vh.
REQ-039 The hazard comparator SHALL be one sub-module, hazard_detect, which is purely combinational.

Verification
REQ-040 Scenario: id_mem_op=LDW, id_dst_addr=5, id_gpr_we_=0, ra_used=1, ra_addr=5 for 1 cycle -> if_stall=1 and id_flush=1 for exactly that cycle.
REQ-041 Scenario: the same stimulus with id_dst_addr=0 -> no stall and no flush.
REQ-042 Scenario: cp2_req=1, with cp2_ack arriving 3 cycles after issue -> cp2_irenable_s is high for 1 cycle and stalls are high for 4 cycles total, with no cp2_err.
REQ-043 Scenario: cp2_req=1 with no ack and CP2_TIMEOUT=4 -> cp2_err pulses in the 4th CP2_WAIT cycle, then the FSM is IDLE.
REQ-044 Scenario: exp_valid=1 during CP2_WAIT -> if_flush=1 and id_flush=1 for 2 cycles, with no cp2_err.
REQ-045 Scenario: br_taken=1 together with a load-use hazard -> stall/bubble only and no if_flush; on the following cycle br_taken=1 -> if_flush=1.

Source files
------------

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared widths, opcodes, FSM encoding and control bundle for pipe_ctrl_unit.
// PIPE_CTRL_ST_* encodings live here so every stage sees the same values.
package pipe_ctrl_unit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int MEM_OP_W   = 2;
    localparam int CP2_CNT_W  = 8;
    localparam int PERF_CNT_W = 16;

    localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = 2'd0;
    localparam logic [MEM_OP_W-1:0] MEM_OP_LDW = 2'd1;
    localparam logic [MEM_OP_W-1:0] MEM_OP_STW = 2'd2;

    typedef enum logic [1:0] {
        PIPE_CTRL_ST_IDLE      = 2'd0,
        PIPE_CTRL_ST_CP2_ISSUE = 2'd1,
        PIPE_CTRL_ST_CP2_WAIT  = 2'd2,
        PIPE_CTRL_ST_EXC_FLUSH = 2'd3
    } pipe_ctrl_state_t;

    typedef struct packed {
        logic if_stall;
        logic id_stall;
        logic if_flush;
        logic id_flush;
        logic cp2_irenable_s;
        logic cp2_err;
    } pipe_ctl_t;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(
        input logic [PERF_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_hazard_detect.sv
// Load-use comparator: a load in ID/EX whose result feeds the decoded op.
// Purely combinational.
module hazard_detect
    import pipe_ctrl_unit_pkg::*;
(
    input  logic                  id_en,
    input  logic [MEM_OP_W-1:0]   id_mem_op,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_gpr_we_,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    input  logic                  ra_used,
    input  logic                  rb_used,
    output logic                  load_hazard
);

    logic is_load;
    logic ra_hit;
    logic rb_hit;

    always_comb begin
        is_load = id_en
               && (id_mem_op == MEM_OP_LDW)
               && !id_gpr_we_
               && (id_dst_addr != '0);
        ra_hit  = ra_used && (ra_addr == id_dst_addr);
        rb_hit  = rb_used && (rb_addr == id_dst_addr);
        load_hazard = is_load && (ra_hit || rb_hit);
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline stall/flush controller with CP2 issue/ack sequencing.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush cycle counters.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int CP2_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_en,
    input  logic [MEM_OP_W-1:0]   id_mem_op,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_gpr_we_,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    input  logic                  ra_used,
    input  logic                  rb_used,
    input  logic                  br_taken,
    input  logic                  exp_valid,
    input  logic                  cp2_req,
    input  logic                  cp2_ack,
    output logic                  if_stall,
    output logic                  id_stall,
    output logic                  if_flush,
    output logic                  id_flush,
    output logic                  cp2_irenable_s,
    output logic                  cp2_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [CP2_CNT_W-1:0] CP2_TERM = CP2_CNT_W'(CP2_TIMEOUT - 1);

    pipe_ctrl_state_t       state;
    pipe_ctrl_state_t       state_nxt;
    logic [CP2_CNT_W-1:0]   cnt;
    logic                   cnt_clr;
    logic                   cnt_inc;
    logic                   load_hazard;
    pipe_ctl_t              ctl;

    hazard_detect u_hazard_detect (
        .id_en       (id_en),
        .id_mem_op   (id_mem_op),
        .id_dst_addr (id_dst_addr),
        .id_gpr_we_  (id_gpr_we_),
        .ra_addr     (ra_addr),
        .rb_addr     (rb_addr),
        .ra_used     (ra_used),
        .rb_used     (rb_used),
        .load_hazard (load_hazard)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PIPE_CTRL_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc && (cnt != CP2_TERM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        ctl       = '0;
        if (exp_valid) begin
            ctl.if_flush = 1'b1;
            ctl.id_flush = 1'b1;
            state_nxt    = PIPE_CTRL_ST_EXC_FLUSH;
        end else begin
            unique case (state)
                PIPE_CTRL_ST_IDLE: begin
                    if (load_hazard) begin
                        ctl.if_stall = 1'b1;
                        ctl.id_flush = 1'b1;
                    end else begin
                        ctl.if_flush = br_taken;
                        if (cp2_req) begin
                            state_nxt = PIPE_CTRL_ST_CP2_ISSUE;
                        end
                    end
                end
                PIPE_CTRL_ST_CP2_ISSUE: begin
                    ctl.cp2_irenable_s = 1'b1;
                    ctl.if_stall       = 1'b1;
                    ctl.id_stall       = 1'b1;
                    cnt_clr            = 1'b1;
                    state_nxt          = PIPE_CTRL_ST_CP2_WAIT;
                end
                PIPE_CTRL_ST_CP2_WAIT: begin
                    if (cp2_ack) begin
                        state_nxt = PIPE_CTRL_ST_IDLE;
                    end else if (cnt == CP2_TERM) begin
                        // abort: drop the CP2 op from ID, let IF advance
                        ctl.cp2_err  = 1'b1;
                        ctl.id_flush = 1'b1;
                        state_nxt    = PIPE_CTRL_ST_IDLE;
                    end else begin
                        ctl.if_stall = 1'b1;
                        ctl.id_stall = 1'b1;
                        cnt_inc      = 1'b1;
                    end
                end
                PIPE_CTRL_ST_EXC_FLUSH: begin
                    ctl.if_flush = 1'b1;
                    ctl.id_flush = 1'b1;
                    state_nxt    = PIPE_CTRL_ST_IDLE;
                end
                default: begin
                    state_nxt = PIPE_CTRL_ST_IDLE;
                end
            endcase
        end
        if (reset) begin
            ctl = '0;
        end
    end

    assign if_stall       = ctl.if_stall;
    assign id_stall       = ctl.id_stall;
    assign if_flush       = ctl.if_flush;
    assign id_flush       = ctl.id_flush;
    assign cp2_irenable_s = ctl.cp2_irenable_s;
    assign cp2_err        = ctl.cp2_err;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctl.if_stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (ctl.if_flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_pipe_ctrl_unit;
    import pipe_ctrl_unit_pkg::*;

    localparam int TMO = 4;

    logic                  clk;
    logic                  reset;
    logic                  id_en;
    logic [MEM_OP_W-1:0]   id_mem_op;
    logic [REG_ADDR_W-1:0] id_dst_addr;
    logic                  id_gpr_we_;
    logic [REG_ADDR_W-1:0] ra_addr;
    logic [REG_ADDR_W-1:0] rb_addr;
    logic                  ra_used;
    logic                  rb_used;
    logic                  br_taken;
    logic                  exp_valid;
    logic                  cp2_req;
    logic                  cp2_ack;
    logic                  if_stall;
    logic                  id_stall;
    logic                  if_flush;
    logic                  id_flush;
    logic                  cp2_irenable_s;
    logic                  cp2_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0]           stall_cnt;
    logic [15:0]           flush_cnt;
`endif

    pipe_ctrl_unit #(.CP2_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_en          (id_en),
        .id_mem_op      (id_mem_op),
        .id_dst_addr    (id_dst_addr),
        .id_gpr_we_     (id_gpr_we_),
        .ra_addr        (ra_addr),
        .rb_addr        (rb_addr),
        .ra_used        (ra_used),
        .rb_used        (rb_used),
        .br_taken       (br_taken),
        .exp_valid      (exp_valid),
        .cp2_req        (cp2_req),
        .cp2_ack        (cp2_ack),
        .if_stall       (if_stall),
        .id_stall       (id_stall),
        .if_flush       (if_flush),
        .id_flush       (id_flush),
        .cp2_irenable_s (cp2_irenable_s),
        .cp2_err        (cp2_err)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // model: what the controller is doing, in plain terms
    bit m_exc_tail;
    bit m_issuing;
    bit m_waiting;
    int m_waited;
    int m_stalls;
    int m_flushes;
    bit rst_done;

    // per-scenario observations
    int o_cyc, o_ifs, o_ids, o_iff, o_idf, o_ire, o_err, o_err_at;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_hazard();
        return id_en && id_mem_op == MEM_OP_LDW && !id_gpr_we_
            && id_dst_addr != 0
            && ((ra_used && ra_addr == id_dst_addr)
             || (rb_used && rb_addr == id_dst_addr));
    endfunction

    // expected {if_stall,id_stall,if_flush,id_flush,irenable,err}
    task automatic model(output logic [5:0] e);
        e = '0;
        if (reset) begin
            m_exc_tail = 0; m_issuing = 0; m_waiting = 0; m_waited = 0;
        end else if (exp_valid) begin
            e = 6'b001100;
            m_exc_tail = 1; m_issuing = 0; m_waiting = 0;
        end else if (m_exc_tail) begin
            e = 6'b001100;
            m_exc_tail = 0;
        end else if (m_issuing) begin
            e = 6'b110010;
            m_issuing = 0; m_waiting = 1; m_waited = 0;
        end else if (m_waiting) begin
            if (cp2_ack) begin
                m_waiting = 0;
            end else if (m_waited == TMO - 1) begin
                e = 6'b000101;
                m_waiting = 0;
            end else begin
                e = 6'b110000;
                m_waited++;
            end
        end else if (is_hazard()) begin
            e = 6'b100100;
        end else begin
            e[3] = br_taken;
            if (cp2_req) m_issuing = 1;
        end
    endtask

    task automatic clr_obs();
        o_cyc = 0; o_ifs = 0; o_ids = 0; o_iff = 0; o_idf = 0;
        o_ire = 0; o_err = 0; o_err_at = -1;
    endtask

    // called just after a rising edge with inputs already set
    task automatic cycle();
        logic [5:0] e;
        logic [5:0] g;
        #4;
        g = {if_stall, id_stall, if_flush, id_flush, cp2_irenable_s, cp2_err};
`ifdef PIPE_CTRL_PERF_EN
        if (rst_done) begin
            check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
            check("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
        end
`endif
        model(e);
        check("ctl", 32'(g), 32'(e));
        check("if_stall_flush", 32'(if_stall & if_flush), 0);
        check("id_stall_flush", 32'(id_stall & id_flush), 0);
        if (reset) begin
            m_stalls = 0; m_flushes = 0;
        end else begin
            if (e[5] && m_stalls < 65535) m_stalls++;
            if (e[3] && m_flushes < 65535) m_flushes++;
        end
        if (reset) rst_done = 1;
        o_ifs += int'(if_stall); o_ids += int'(id_stall);
        o_iff += int'(if_flush); o_idf += int'(id_flush);
        o_ire += int'(cp2_irenable_s);
        if (cp2_err) begin
            o_err++;
            if (o_err_at < 0) o_err_at = o_cyc;
        end
        o_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_en = 0; id_mem_op = MEM_OP_NOP; id_dst_addr = 0;
        id_gpr_we_ = 1; ra_addr = 0; rb_addr = 0; ra_used = 0; rb_used = 0;
        br_taken = 0; exp_valid = 0; cp2_req = 0; cp2_ack = 0;
    endtask

    task automatic ldu(input logic [4:0] dst);
        id_en = 1; id_mem_op = MEM_OP_LDW; id_dst_addr = dst;
        id_gpr_we_ = 0; ra_used = 1; ra_addr = dst;
    endtask

    task automatic idle_n(input int n);
        idle_in();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        m_exc_tail = 0; m_issuing = 0; m_waiting = 0; m_waited = 0;
        m_stalls = 0; m_flushes = 0; rst_done = 0;
        clr_obs();
        idle_in();
        reset = 1;
        @(posedge clk);
        #1;
        // reset gates outputs even with a hazard and a branch present
        ldu(5'd5);
        br_taken = 1;
        cycle();
        cycle();
        check("rst_quiet", 32'(o_ifs + o_iff + o_idf), 0);
        reset = 0;
        idle_n(2);

        // load-use hazard for one cycle
        clr_obs();
        ldu(5'd5);
        cycle();
        idle_n(2);
        check("ldu_if_stall", 32'(o_ifs), 1);
        check("ldu_id_flush", 32'(o_idf), 1);
        check("ldu_id_stall", 32'(o_ids), 0);

        // destination r0 is never a hazard
        clr_obs();
        ldu(5'd0);
        cycle();
        idle_n(2);
        check("r0_no_stall", 32'(o_ifs + o_ids), 0);
        check("r0_no_flush", 32'(o_iff + o_idf), 0);

        // CP2 ack on the terminal wait cycle: ack wins
        clr_obs();
        cp2_req = 1;
        cycle();
        idle_n(4);
        cp2_ack = 1;
        cycle();
        idle_n(2);
        check("cp2_ire", 32'(o_ire), 1);
        check("cp2_stalls", 32'(o_ifs), 4);
        check("cp2_id_stalls", 32'(o_ids), 4);
        check("cp2_ack_no_err", 32'(o_err), 0);

        // CP2 timeout with no ack
        clr_obs();
        cp2_req = 1;
        cycle();
        idle_n(7);
        check("tmo_err", 32'(o_err), 1);
        check("tmo_err_at", 32'(o_err_at), 5);
        check("tmo_stalls", 32'(o_ifs), 4);
        // back in IDLE: a branch flushes IF right away
        clr_obs();
        br_taken = 1;
        cycle();
        idle_n(1);
        check("tmo_idle_br", 32'(o_iff), 1);

        // exception during CP2 wait
        clr_obs();
        cp2_req = 1;
        cycle();
        idle_n(3);
        exp_valid = 1;
        cycle();
        idle_n(6);
        check("exc_if_flush", 32'(o_iff), 2);
        check("exc_id_flush", 32'(o_idf), 2);
        check("exc_no_err", 32'(o_err), 0);
        check("exc_no_ire_extra", 32'(o_ire), 1);

        // branch with hazard: bubble only, then the branch flushes
        clr_obs();
        ldu(5'd9);
        br_taken = 1;
        cycle();
        check("br_hz_no_flush", 32'(o_iff), 0);
        idle_in();
        br_taken = 1;
        cycle();
        idle_n(1);
        check("br_flush", 32'(o_iff), 1);
        check("br_hz_stall", 32'(o_ifs), 1);

        // reset during CP2 wait
        clr_obs();
        cp2_req = 1;
        cycle();
        idle_n(2);
        reset = 1;
        cycle();
        reset = 0;
        idle_n(8);
        check("rst_wait_no_err", 32'(o_err), 0);
        check("rst_wait_stalls", 32'(o_ifs), 2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            id_en       = ($urandom_range(0, 3) != 0);
            id_mem_op   = MEM_OP_W'($urandom_range(0, 3));
            id_dst_addr = REG_ADDR_W'($urandom_range(0, 7));
            id_gpr_we_  = ($urandom_range(0, 3) == 0);
            ra_used     = $urandom_range(0, 1) != 0;
            rb_used     = $urandom_range(0, 1) != 0;
            ra_addr     = ($urandom_range(0, 1) != 0) ? id_dst_addr
                        : REG_ADDR_W'($urandom);
            rb_addr     = ($urandom_range(0, 2) == 0) ? id_dst_addr
                        : REG_ADDR_W'($urandom);
            br_taken    = ($urandom_range(0, 3) == 0);
            exp_valid   = ($urandom_range(0, 19) == 0);
            cp2_req     = ($urandom_range(0, 3) == 0);
            cp2_ack     = ($urandom_range(0, 4) == 0);
            cycle();
        end
        idle_n(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
